// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: FSM state type and the
// encodings exposed on state_view.
`timescale 1ns/1ps
package keypad_pkg;

  localparam logic [1:0] SV_SCAN     = 2'b00;
  localparam logic [1:0] SV_DEBOUNCE = 2'b01;
  localparam logic [1:0] SV_HELD     = 2'b10;
  localparam logic [1:0] SV_RELEASE  = 2'b11;

  typedef enum logic [1:0] {
    ST_SCAN     = SV_SCAN,
    ST_DEBOUNCE = SV_DEBOUNCE,
    ST_HELD     = SV_HELD,
    ST_RELEASE  = SV_RELEASE
  } kp_state_e;

endpackage

// File: rtl/keypad_debounce.sv
// Consecutive-match counter shared by the press (DEBOUNCE) and release
// (RELEASE) phases; done fires on the DEBOUNCE_CYCLES-th matching sample.
`timescale 1ns/1ps
module keypad_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic match,
  output logic done
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign done = sample_en && match && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || !sample_en || !match || done) begin
      cnt <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_keypad_scan.sv
// Column-scanning matrix keypad controller with debounce and a valid/ready
// key output. Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
`timescale 1ns/1ps
module matrix_keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SCAN_DIV        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
`endif
) (
  input  logic                            CLK,
  input  logic                            rst,
  input  logic [ROWS-1:0]                 row,
  output logic [COLS-1:0]                 col,
  output logic [$clog2(ROWS*COLS)-1:0]    key_code,
  output logic                            key_valid,
  input  logic                            key_ready,
  output logic                            pressed,
  output logic                            overrun,
  output logic [1:0]                      state_view
);

  localparam int unsigned CI_W  = $clog2(COLS);
  localparam int unsigned DIV_W = $clog2(SCAN_DIV + 1);
  localparam int unsigned KC_W  = $clog2(ROWS * COLS);
  localparam logic [CI_W-1:0]  COL_LAST = CI_W'(COLS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  kp_state_e         state, state_nx;
  logic [CI_W-1:0]   col_idx;
  logic [DIV_W-1:0]  div_cnt;
  logic [ROWS-1:0]   cap_row;
  logic [KC_W-1:0]   new_code;
  logic              slot_end;
  logic              capture, advance, confirm, emit, hs;
  logic              db_en, db_match, db_done;

  assign slot_end = (div_cnt == DIV_LAST);
  assign hs       = key_valid && key_ready;

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (CLK),
    .rst      (rst),
    .sample_en(db_en),
    .match    (db_match),
    .done     (db_done)
  );

  always_ff @(posedge CLK) begin
    if (rst) state <= ST_SCAN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    advance  = 1'b0;
    confirm  = 1'b0;
    db_en    = 1'b0;
    db_match = 1'b0;
    case (state)
      ST_SCAN: begin
        if (slot_end) begin
          if (row != '1) begin
            state_nx = ST_DEBOUNCE;
            capture  = 1'b1;
          end else begin
            advance  = 1'b1;
          end
        end
      end
      ST_DEBOUNCE: begin
        db_en    = 1'b1;
        db_match = (row == cap_row);
        if (!db_match) begin
          state_nx = ST_SCAN;
          advance  = 1'b1;
        end else if (db_done) begin
          state_nx = ST_HELD;
          confirm  = 1'b1;
        end
      end
      ST_HELD: begin
        if (row == '1) state_nx = ST_RELEASE;
      end
      ST_RELEASE: begin
        db_en    = 1'b1;
        db_match = (row == '1);
        if (!db_match) begin
          state_nx = ST_HELD;
        end else if (db_done) begin
          state_nx = ST_SCAN;
          advance  = 1'b1;
        end
      end
      default: state_nx = ST_SCAN;
    endcase
  end

  // Lowest-index asserted (low) row wins; shifting avoids a variable bit-select.
  always_comb begin
    logic [ROWS-1:0] tmp;
    int unsigned     row_sel;
    logic            found;
    tmp     = cap_row;
    row_sel = 0;
    found   = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!found && !tmp[0]) begin
        row_sel = r;
        found   = 1'b1;
      end
      tmp = tmp >> 1;
    end
    new_code = KC_W'(row_sel * COLS + 32'(col_idx));
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_lim;
  logic             rep_first;
  logic             rep_fire;

  assign rep_lim  = rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);
  assign rep_fire = (state == ST_HELD) && (rep_cnt == rep_lim);
  assign emit     = confirm | rep_fire;

  always_ff @(posedge CLK) begin
    if (rst || state != ST_HELD) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else if (rep_cnt != rep_lim) begin
      rep_cnt   <= rep_cnt + 1'b1;
    end
  end
`else
  assign emit = confirm;
`endif

  // Column rotation: div_cnt parks on its last value while the column is frozen.
  always_ff @(posedge CLK) begin
    if (rst) begin
      col_idx <= '0;
      div_cnt <= '0;
      cap_row <= '1;
    end else begin
      if (advance) begin
        div_cnt <= '0;
        col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
      end else if (state == ST_SCAN && div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (capture) cap_row <= row;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (emit) begin
        if (!key_valid || hs) begin
          key_code  <= new_code;
          key_valid <= 1'b1;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (hs) begin
        key_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    col = ~(COLS'(1) << col_idx);
  end

  assign pressed    = (state == ST_HELD) || (state == ST_RELEASE);
  assign state_view = state;

endmodule
